// File: rtl/usb_phy_pkg.sv
// Shared line-state encodings, timing constants and FSM state type for the
// USB full-speed pin front end.
package usb_phy_pkg;

    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;

    localparam int unsigned FS_CLK_HZ = 48_000_000;

    // 2.5 us of SE0 and 10 ms of detach, expressed in FS_CLK_HZ cycles
    localparam int unsigned BUS_RESET_CYCLES   = FS_CLK_HZ / 400_000;
    localparam int unsigned DETACH_10MS_CYCLES = FS_CLK_HZ / 100;

    typedef enum logic {
        ST_DETACHED,
        ST_CONNECTED
    } conn_state_t;

endpackage

// File: rtl/usb_line_sync.sv
// Multi-flop synchroniser for a small bus of asynchronous pin lines; every
// stage resets to RESET_VAL so the core sees an idle bus out of reset.
module usb_line_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WIDTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/usb_phy_io.sv
// USB full-speed pin front end: transmit pass-through, synchronised and
// echo-masked receive, SE0 bus-reset detection and soft-connect pull-up FSM.
module usb_phy_io
    import usb_phy_pkg::*;
#(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned ECHO_MASK_CYCLES = 4,
    parameter int unsigned RESET_CYCLES     = BUS_RESET_CYCLES,
    parameter int unsigned DETACH_CYCLES    = DETACH_10MS_CYCLES
) (
    input  logic clk_48mhz,
    input  logic reset,
    input  logic usb_p_tx,
    input  logic usb_n_tx,
    input  logic usb_tx_en,
    output logic usb_p_rx,
    output logic usb_n_rx,
    input  logic connect_en,
    input  logic detach_req,
    output logic bus_reset,
    output logic connected,
    output logic pin_p_out,
    output logic pin_n_out,
    output logic pin_oe,
    input  logic pin_p_in,
    input  logic pin_n_in,
    output logic pin_pullup
);

    localparam int unsigned MASK_W = (ECHO_MASK_CYCLES > 0) ? $clog2(ECHO_MASK_CYCLES + 1) : 1;
    localparam int unsigned SE0_W  = $clog2(RESET_CYCLES + 1);
    localparam int unsigned TMR_W  = $clog2(DETACH_CYCLES + 1);

    assign pin_p_out = usb_p_tx;
    assign pin_n_out = usb_n_tx;
    assign pin_oe    = usb_tx_en;

    logic [1:0] line_sync;

    usb_line_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (2),
        .RESET_VAL   (LS_J)
    ) u_line_sync (
        .clk_i (clk_48mhz),
        .rst_i (reset),
        .d_i   ({pin_p_in, pin_n_in}),
        .q_o   (line_sync)
    );

    logic [MASK_W-1:0] mask_cnt_q, mask_cnt_d;
    logic              masked;
    logic [SE0_W-1:0]  se0_cnt_q, se0_cnt_d;
    logic              se0_now;
    logic              bus_reset_q, bus_reset_d;

    assign masked = usb_tx_en | (mask_cnt_q != '0);
    assign {usb_p_rx, usb_n_rx} = masked ? LS_J : line_sync;
    assign se0_now = (line_sync == LS_SE0) && !masked;

    always_comb begin
        mask_cnt_d = mask_cnt_q;
        if (usb_tx_en) begin
            mask_cnt_d = MASK_W'(ECHO_MASK_CYCLES);
        end else if (mask_cnt_q != '0) begin
            mask_cnt_d = mask_cnt_q - 1'b1;
        end
    end

    // bus_reset also requires the current sample to be SE0 so it drops on
    // the first cycle after the line leaves SE0, not one cycle later
    always_comb begin
        se0_cnt_d = '0;
        if (se0_now) begin
            se0_cnt_d = (se0_cnt_q == SE0_W'(RESET_CYCLES)) ? se0_cnt_q : se0_cnt_q + 1'b1;
        end
        bus_reset_d = se0_now && (se0_cnt_q == SE0_W'(RESET_CYCLES));
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            mask_cnt_q  <= '0;
            se0_cnt_q   <= '0;
            bus_reset_q <= 1'b0;
        end else begin
            mask_cnt_q  <= mask_cnt_d;
            se0_cnt_q   <= se0_cnt_d;
            bus_reset_q <= bus_reset_d;
        end
    end

    assign bus_reset = bus_reset_q;

    conn_state_t      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             pullup_q, pullup_d;
    logic             connected_q, connected_d;

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q     <= ST_DETACHED;
            timer_q     <= '0;
            pullup_q    <= 1'b0;
            connected_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pullup_q    <= pullup_d;
            connected_q <= connected_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_DETACHED: begin
                if (detach_req || !connect_en) begin
                    timer_d = '0;
                end else if (timer_q == TMR_W'(DETACH_CYCLES - 1)) begin
                    state_d = ST_CONNECTED;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_CONNECTED: begin
                if (detach_req || !connect_en) begin
                    state_d = ST_DETACHED;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = ST_DETACHED;
                timer_d = '0;
            end
        endcase
    end

    // Outputs decode the next state so the registered copies track state_q
    always_comb begin
        pullup_d    = (state_d == ST_CONNECTED);
        connected_d = (state_d == ST_CONNECTED);
    end

    assign pin_pullup = pullup_q;
    assign connected  = connected_q;

endmodule

// File: tb/tb_usb_phy_io.sv
// Directed bench for usb_phy_io: stimulus schedules expected pin/status values
// at absolute cycle numbers; a negedge monitor compares them as cycles elapse.
module tb_usb_phy_io;
    import usb_phy_pkg::*;

    localparam int unsigned DET = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, usb_p_tx, usb_n_tx, usb_tx_en, connect_en, detach_req;
    logic pin_p_in, pin_n_in;
    logic usb_p_rx, usb_n_rx, bus_reset, connected;
    logic pin_p_out, pin_n_out, pin_oe, pin_pullup;

    usb_phy_io #(
        .SYNC_STAGES      (2),
        .ECHO_MASK_CYCLES (4),
        .RESET_CYCLES     (120),
        .DETACH_CYCLES    (DET)
    ) dut (
        .clk_48mhz  (clk),
        .reset      (reset),
        .usb_p_tx   (usb_p_tx),
        .usb_n_tx   (usb_n_tx),
        .usb_tx_en  (usb_tx_en),
        .usb_p_rx   (usb_p_rx),
        .usb_n_rx   (usb_n_rx),
        .connect_en (connect_en),
        .detach_req (detach_req),
        .bus_reset  (bus_reset),
        .connected  (connected),
        .pin_p_out  (pin_p_out),
        .pin_n_out  (pin_n_out),
        .pin_oe     (pin_oe),
        .pin_p_in   (pin_p_in),
        .pin_n_in   (pin_n_in),
        .pin_pullup (pin_pullup)
    );

    typedef enum int {S_P_RX, S_N_RX, S_BUS_RESET, S_PULLUP, S_CONNECTED, S_OE, S_P_OUT} sig_e;
    typedef struct {
        int unsigned cyc;
        sig_e        sig;
        logic        val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic pick(sig_e s);
        case (s)
            S_P_RX:      return usb_p_rx;
            S_N_RX:      return usb_n_rx;
            S_BUS_RESET: return bus_reset;
            S_PULLUP:    return pin_pullup;
            S_CONNECTED: return connected;
            S_OE:        return pin_oe;
            default:     return pin_p_out;
        endcase
    endfunction

    task automatic expect_at(input int unsigned off, input sig_e s, input logic v, input string nm);
        exp_t e;
        e.cyc  = cyc + off;
        e.sig  = s;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                n_checks++;
                if (pick(sb[i].sig) !== sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got %b expected %b", sb[i].name, cyc, pick(sb[i].sig), sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: cycle %0d was never sampled", sb[i].name, sb[i].cyc);
                sb.delete(i);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        usb_p_tx   = 1'b0;
        usb_n_tx   = 1'b0;
        usb_tx_en  = 1'b0;
        connect_en = 1'b1;
        detach_req = 1'b0;
        {pin_p_in, pin_n_in} = LS_J;
        step(3);

        // reset state and initial connect delay
        reset = 1'b0;
        expect_at(0,   S_PULLUP,    1'b0, "rst_pullup");
        expect_at(0,   S_CONNECTED, 1'b0, "rst_connected");
        expect_at(0,   S_BUS_RESET, 1'b0, "rst_bus_reset");
        expect_at(0,   S_P_RX,      1'b1, "rst_p_rx");
        expect_at(0,   S_N_RX,      1'b0, "rst_n_rx");
        expect_at(DET - 1, S_PULLUP,    1'b0, "init_pullup_low_end");
        expect_at(DET,     S_PULLUP,    1'b1, "init_pullup_high");
        expect_at(DET,     S_CONNECTED, 1'b1, "init_connected");
        step(DET + 5);

        // K through the synchroniser
        {pin_p_in, pin_n_in} = LS_K;
        expect_at(1, S_P_RX, 1'b1, "k_not_yet");
        expect_at(2, S_P_RX, 1'b0, "k_p_rx");
        expect_at(2, S_N_RX, 1'b1, "k_n_rx");
        step(5);
        {pin_p_in, pin_n_in} = LS_J;
        expect_at(2, S_P_RX, 1'b1, "j_back_p_rx");
        step(6);

        // transmit with SE0 echo: rx masked for 10 + 4 cycles
        usb_tx_en = 1'b1;
        usb_p_tx  = 1'b0;
        usb_n_tx  = 1'b1;
        {pin_p_in, pin_n_in} = LS_SE0;
        expect_at(0,  S_OE,        1'b1, "tx_oe");
        expect_at(0,  S_P_OUT,     1'b0, "tx_p_out");
        expect_at(0,  S_P_RX,      1'b1, "tx_mask_start");
        expect_at(9,  S_P_RX,      1'b1, "tx_mask_last_tx");
        expect_at(13, S_P_RX,      1'b1, "echo_mask_last");
        expect_at(13, S_N_RX,      1'b0, "echo_mask_last_n");
        expect_at(14, S_P_RX,      1'b0, "echo_mask_expired");
        expect_at(14, S_OE,        1'b0, "tx_oe_off");
        expect_at(16, S_BUS_RESET, 1'b0, "tx_no_bus_reset_a");
        expect_at(20, S_BUS_RESET, 1'b0, "tx_no_bus_reset_b");
        step(10);
        usb_tx_en = 1'b0;
        step(6);
        {pin_p_in, pin_n_in} = LS_J;
        step(10);

        // SE0 one cycle short of the threshold
        {pin_p_in, pin_n_in} = LS_SE0;
        expect_at(121, S_BUS_RESET, 1'b0, "se0_119_a");
        expect_at(122, S_BUS_RESET, 1'b0, "se0_119_b");
        expect_at(124, S_BUS_RESET, 1'b0, "se0_119_c");
        step(119);
        {pin_p_in, pin_n_in} = LS_J;
        step(10);

        // SE0 long enough for bus reset
        {pin_p_in, pin_n_in} = LS_SE0;
        expect_at(2,   S_P_RX,      1'b0, "se0_rx_p");
        expect_at(122, S_BUS_RESET, 1'b0, "bus_reset_before");
        expect_at(123, S_BUS_RESET, 1'b1, "bus_reset_rise");
        expect_at(132, S_BUS_RESET, 1'b1, "bus_reset_hold");
        expect_at(133, S_BUS_RESET, 1'b0, "bus_reset_fall");
        expect_at(133, S_PULLUP,    1'b1, "bus_reset_fsm_indep");
        step(130);
        {pin_p_in, pin_n_in} = LS_J;
        step(10);

        // detach_req with a restart mid-window
        detach_req = 1'b1;
        expect_at(1,   S_PULLUP,    1'b0, "detach_pullup_low");
        expect_at(1,   S_CONNECTED, 1'b0, "detach_disconnected");
        expect_at(101, S_PULLUP,    1'b0, "detach_restarted");
        expect_at(140, S_PULLUP,    1'b0, "detach_restart_end");
        expect_at(141, S_PULLUP,    1'b1, "detach_reconnect");
        step(1);
        detach_req = 1'b0;
        step(39);
        detach_req = 1'b1;
        step(1);
        detach_req = 1'b0;
        step(110);

        // detach_req and connect_en drop together, then reconnect
        detach_req = 1'b1;
        connect_en = 1'b0;
        expect_at(1,  S_PULLUP,    1'b0, "dual_pullup_low");
        expect_at(1,  S_CONNECTED, 1'b0, "dual_disconnected");
        expect_at(50, S_PULLUP,    1'b0, "dual_hold");
        step(1);
        detach_req = 1'b0;
        step(49);
        connect_en = 1'b1;
        expect_at(DET - 1, S_PULLUP,    1'b0, "reen_pullup_low_end");
        expect_at(DET,     S_PULLUP,    1'b1, "reen_pullup_high");
        expect_at(DET,     S_CONNECTED, 1'b1, "reen_connected");
        step(DET + 5);

        // reset while transmitting
        reset     = 1'b1;
        usb_tx_en = 1'b1;
        usb_p_tx  = 1'b1;
        usb_n_tx  = 1'b0;
        expect_at(0, S_OE,        1'b1, "rst_tx_oe");
        expect_at(0, S_P_OUT,     1'b1, "rst_tx_p_out");
        expect_at(0, S_P_RX,      1'b1, "rst_tx_p_rx");
        expect_at(1, S_N_RX,      1'b0, "rst_tx_n_rx");
        expect_at(1, S_PULLUP,    1'b0, "rst_mid_pullup");
        expect_at(1, S_CONNECTED, 1'b0, "rst_mid_connected");
        step(3);
        reset     = 1'b0;
        usb_tx_en = 1'b0;
        step(3);

        step(2);
        while (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: pending at end, scheduled cycle %0d", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
